// File: rtl/fn_sweep_pkg.sv
// Shared types and limits for the fn_sweep_ctrl truth-table sequencer.
package fn_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned N_IN_MIN   = 1;
  localparam int unsigned N_IN_MAX   = 4;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;
  // Wide enough to hold SETTLE_MAX-1.
  localparam int unsigned CNT_W      = 4;

  // Number of input combinations for an n-input function.
  function automatic int unsigned num_comb(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/fn_sweep_settle_cnt.sv
// Loadable down-counter with zero flag; times how long fx_in is held.
module fn_sweep_settle_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fn_sweep_ctrl.sv
// Sweeps every input combination of an external combinational function,
// samples its output after a settle time, and compares the measured truth
// table with a latched expected table.
// Build option: define FN_SWEEP_EARLY_STOP_EN to end the sweep at the first
// mismatching combination.
module fn_sweep_ctrl
  import fn_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1,
  localparam int unsigned NC    = num_comb(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NC-1:0]   expected,
  output logic [N_IN-1:0] fx_in,
  input  logic            fx_s,
  output logic            busy,
  output logic            done,
  output logic [NC-1:0]   tbl,
  output logic            pass,
  output logic [N_IN-1:0] fail_idx
);

  localparam logic [N_IN-1:0]  LAST_IDX  = '1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [NC-1:0]     exp_q;
  logic [NC-1:0]     tbl_upd;
  logic              miss_q;
  logic              mismatch;
  logic              cnt_load, cnt_dec, cnt_zero;

  fn_sweep_settle_cnt #(.W(CNT_W)) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign mismatch = (fx_s != exp_q[idx_q]);

  // Measured table including the bit being sampled this cycle.
  always_comb begin
    tbl_upd        = tbl;
    tbl_upd[idx_q] = fx_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, counter control and next index.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          idx_d    = '0;
          cnt_load = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_zero) state_d = SAMPLE;
        else          cnt_dec = 1'b1;
      end
      SAMPLE: begin
`ifdef FN_SWEEP_EARLY_STOP_EN
        if (mismatch || (idx_q == LAST_IDX)) begin
`else
        if (idx_q == LAST_IDX) begin
`endif
          state_d = DONE;
        end else begin
          state_d  = DRIVE;
          idx_d    = idx_q + 1'b1;
          cnt_load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Index, latched expectation, results and the registered fx_in drive.
  // fx_in follows the next state so it already shows idx on the first DRIVE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      exp_q    <= '0;
      tbl      <= '0;
      pass     <= 1'b0;
      fail_idx <= '0;
      miss_q   <= 1'b0;
      fx_in    <= '0;
    end else begin
      idx_q <= idx_d;
      if ((state_d == DRIVE) || (state_d == SAMPLE)) fx_in <= idx_d;
      else                                             fx_in <= '0;
      if ((state_q == IDLE) && start) begin
        exp_q    <= expected;
        tbl      <= '0;
        pass     <= 1'b0;
        fail_idx <= '0;
        miss_q   <= 1'b0;
      end
      if (state_q == SAMPLE) begin
        tbl <= tbl_upd;
        if (mismatch && !miss_q) begin
          miss_q   <= 1'b1;
          fail_idx <= idx_q;
        end
        if (state_d == DONE) pass <= (tbl_upd == exp_q);
      end
    end
  end

endmodule

// File: tb/tb_fn_sweep_ctrl.sv
// Scoreboard bench for fn_sweep_ctrl driving the function f(x,y) = ~x & y.
module tb_fn_sweep_ctrl;

`ifdef FN_SWEEP_EARLY_STOP_EN
  localparam bit ES = 1'b1;
`else
  localparam bit ES = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, a_fx_s, a_busy, a_done, a_pass;
  logic [3:0] a_exp, a_tbl;
  logic [1:0] a_fx_in, a_fail;
  logic       b_start, b_fx_s, b_busy, b_done, b_pass;
  logic [3:0] b_exp, b_tbl;
  logic [1:0] b_fx_in, b_fail;

  assign a_fx_s = ~a_fx_in[1] & a_fx_in[0];
  assign b_fx_s = ~b_fx_in[1] & b_fx_in[0];

  fn_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .expected(a_exp), .fx_in(a_fx_in),
    .fx_s(a_fx_s), .busy(a_busy), .done(a_done), .tbl(a_tbl), .pass(a_pass),
    .fail_idx(a_fail)
  );

  fn_sweep_ctrl #(.N_IN(2), .SETTLE(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .expected(b_exp), .fx_in(b_fx_in),
    .fx_s(b_fx_s), .busy(b_busy), .done(b_done), .tbl(b_tbl), .pass(b_pass),
    .fail_idx(b_fail)
  );

  typedef struct {
    logic [3:0] tbl;
    logic       pass;
    logic [1:0] fidx;
    int         start_cyc;
    int         lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor for instance A: every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        ea = q_a.pop_front();
        check("a_tbl", a_tbl, ea.tbl);
        check("a_pass", a_pass, ea.pass);
        check("a_fail_idx", a_fail, ea.fidx);
        check("a_latency", cyc - ea.start_cyc, ea.lat);
        check("a_busy_at_done", a_busy, 32'd1);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (b_done === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        eb = q_b.pop_front();
        check("b_tbl", b_tbl, eb.tbl);
        check("b_pass", b_pass, eb.pass);
        check("b_fail_idx", b_fail, eb.fidx);
        check("b_latency", cyc - eb.start_cyc, eb.lat);
      end
    end
  end

  // Issue one start pulse to A and queue its expected result; returns at
  // #1 after the accepting edge with that edge's cycle number.
  task automatic sweep_a(input logic [3:0] exp_v, input logic [3:0] etbl,
                         input logic ep, input logic [1:0] efi, input int elat,
                         output int sc);
    @(negedge clk);
    a_exp   = exp_v;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    sc      = cyc;
    a_start = 1'b0;
    q_a.push_back('{etbl, ep, efi, sc, elat});
  endtask

  task automatic wait_drain(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? q_a.size() : q_b.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check((which == 0) ? "a_drain_timeout" : "b_drain_timeout",
          (which == 0) ? q_a.size() : q_b.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc;
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_exp = '0; b_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", a_busy, 32'd0);
    check("rst_done", a_done, 32'd0);
    check("rst_fx_in", a_fx_in, 32'd0);
    check("rst_tbl", a_tbl, 32'd0);
    check("rst_pass", a_pass, 32'd0);
    check("rst_fail_idx", a_fail, 32'd0);
    rst = 1'b0;

    // Matching table; fx_in walks 0,0,1,1,2,2,3,3.
    sweep_a(4'b0010, 4'b0010, 1'b1, 2'd0, 8, sc);
    for (int k = 0; k < 8; k++) begin
      check("a_fx_in_seq", a_fx_in, k / 2);
      check("a_busy_seq", a_busy, 32'd1);
      @(posedge clk);
      #1;
    end
    wait_drain(0, 40);
    check("a_fx_in_idle", a_fx_in, 32'd0);
    check("a_busy_idle", a_busy, 32'd0);

    // Mismatch at index 2.
    sweep_a(4'b0110, 4'b0010, 1'b0, 2'd2, ES ? 6 : 8, sc);
    wait_drain(0, 40);
    repeat (3) @(negedge clk);
    check("a_hold_tbl", a_tbl, 32'h2);
    check("a_hold_pass", a_pass, 32'd0);
    check("a_hold_fail_idx", a_fail, 32'd2);

    // Mismatch at index 0.
    sweep_a(4'b0011, ES ? 4'b0000 : 4'b0010, 1'b0, 2'd0, ES ? 2 : 8, sc);
    wait_drain(0, 40);

    // Start re-pulsed and expected changed mid-sweep: both ignored.
    sweep_a(4'b0010, 4'b0010, 1'b1, 2'd0, 8, sc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_exp   = 4'b1111;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    wait_drain(0, 40);
    repeat (12) @(negedge clk);

    // Reset at the fifth cycle of a sweep aborts it with no done pulse.
    @(negedge clk);
    a_exp   = 4'b0010;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", a_busy, 32'd0);
    check("abort_fx_in", a_fx_in, 32'd0);
    check("abort_tbl", a_tbl, 32'd0);
    check("abort_pass", a_pass, 32'd0);
    check("abort_done", a_done, 32'd0);
    repeat (12) @(negedge clk);
    sweep_a(4'b0010, 4'b0010, 1'b1, 2'd0, 8, sc);
    wait_drain(0, 40);

    // start held high: second sweep starts after one idle cycle.
    @(negedge clk);
    a_exp   = 4'b0010;
    a_start = 1'b1;
    @(posedge clk); #1;
    sc = cyc;
    q_a.push_back('{4'b0010, 1'b1, 2'd0, sc, 8});
    q_a.push_back('{4'b0010, 1'b1, 2'd0, sc + 10, 8});
    repeat (10) @(posedge clk);
    #1;
    a_start = 1'b0;
    wait_drain(0, 60);

    // SETTLE=3 instance: each value held four cycles, done at cycle 16.
    @(negedge clk);
    b_exp   = 4'b0010;
    b_start = 1'b1;
    @(posedge clk); #1;
    sc      = cyc;
    b_start = 1'b0;
    q_b.push_back('{4'b0010, 1'b1, 2'd0, sc, 16});
    for (int k = 0; k < 16; k++) begin
      check("b_fx_in_seq", b_fx_in, k / 4);
      @(posedge clk);
      #1;
    end
    wait_drain(1, 40);

    check("queues_empty", q_a.size() + q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
